// File: rtl/decode_prefix_scanner.sv
// x86 legacy-prefix scanner: folds prefix bytes into a bundle and presents it with
// the first non-prefix (or overflowing) byte as the opcode.
module decode_prefix_scanner #(
  parameter int MAX_PREFIX = 14,
  localparam int CNT_W = $clog2(MAX_PREFIX+1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_byte_valid,
  input  logic [7:0]       i_byte,
  output logic             o_byte_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [7:0]       o_opcode,
  output logic             o_lock,
  output logic             o_rep_ne,
  output logic             o_rep_e,
  output logic             o_seg_override,
  output logic [2:0]       o_seg_index,
  output logic             o_opsize,
  output logic             o_addrsize,
  output logic [CNT_W-1:0] o_prefix_count,
  output logic             o_error
);

  typedef enum logic {SCAN = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [7:0]       opcode;
    logic             lock;
    logic             rep_ne;
    logic             rep_e;
    logic             seg_ov;
    logic [2:0]       seg_idx;
    logic             opsize;
    logic             addrsize;
    logic [CNT_W-1:0] count;
    logic             error;
  } bundle_t;

  state_t  state_q;
  bundle_t bnd_q, base, pfx_upd;
  logic    is_pfx, is_seg, at_max;
  logic [2:0] seg_val;

  always_comb begin
    is_pfx  = 1'b1;
    is_seg  = 1'b0;
    seg_val = 3'd0;
    case (i_byte)
      8'h26: begin is_seg = 1'b1; seg_val = 3'd0; end
      8'h2E: begin is_seg = 1'b1; seg_val = 3'd1; end
      8'h36: begin is_seg = 1'b1; seg_val = 3'd2; end
      8'h3E: begin is_seg = 1'b1; seg_val = 3'd3; end
      8'h64: begin is_seg = 1'b1; seg_val = 3'd4; end
      8'h65: begin is_seg = 1'b1; seg_val = 3'd5; end
      8'hF0, 8'hF2, 8'hF3, 8'h66, 8'h67: ;
      default: is_pfx = 1'b0;
    endcase
  end

  // Leaving HOLD always starts from a cleared bundle; a byte taken that cycle is byte 0.
  always_comb begin
    base    = (state_q == HOLD) ? '0 : bnd_q;
    at_max  = (base.count == CNT_W'(MAX_PREFIX));
    pfx_upd = base;
    pfx_upd.count = base.count + CNT_W'(1);
    case (i_byte)
      8'hF0: begin pfx_upd.lock = 1'b1; pfx_upd.rep_ne = 1'b0; pfx_upd.rep_e = 1'b0; end
      8'hF2: begin pfx_upd.lock = 1'b0; pfx_upd.rep_ne = 1'b1; pfx_upd.rep_e = 1'b0; end
      8'hF3: begin pfx_upd.lock = 1'b0; pfx_upd.rep_ne = 1'b0; pfx_upd.rep_e = 1'b1; end
      8'h66: pfx_upd.opsize   = 1'b1;
      8'h67: pfx_upd.addrsize = 1'b1;
      default: ;
    endcase
    if (is_seg) begin
      pfx_upd.seg_ov  = 1'b1;
      pfx_upd.seg_idx = seg_val;
    end
  end

  assign o_byte_ready = !i_flush && (state_q == SCAN || i_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SCAN;
      bnd_q   <= '0;
    end else if (i_flush) begin
      state_q <= SCAN;
      bnd_q   <= '0;
    end else if (state_q == HOLD && !i_ready) begin
      state_q <= HOLD;
    end else if (i_byte_valid) begin
      if (!is_pfx) begin
        bnd_q        <= base;
        bnd_q.opcode <= i_byte;
        state_q      <= HOLD;
      end else if (at_max) begin
        bnd_q        <= base;
        bnd_q.opcode <= i_byte;
        bnd_q.error  <= 1'b1;
        state_q      <= HOLD;
      end else begin
        bnd_q   <= pfx_upd;
        state_q <= SCAN;
      end
    end else begin
      bnd_q   <= base;
      state_q <= SCAN;
    end
  end

  assign o_valid        = (state_q == HOLD);
  assign o_opcode       = bnd_q.opcode;
  assign o_lock         = bnd_q.lock;
  assign o_rep_ne       = bnd_q.rep_ne;
  assign o_rep_e        = bnd_q.rep_e;
  assign o_seg_override = bnd_q.seg_ov;
  assign o_seg_index    = bnd_q.seg_idx;
  assign o_opsize       = bnd_q.opsize;
  assign o_addrsize     = bnd_q.addrsize;
  assign o_prefix_count = bnd_q.count;
  assign o_error        = bnd_q.error;

endmodule

// File: tb/tb_decode_prefix_scanner.sv
// Scoreboard bench: stimulus pushes hand-computed bundles, monitors pop on each handshake.
module tb_decode_prefix_scanner;

  logic       i_clk, i_rst_n;
  logic       flush, bvalid, rdy;
  logic [7:0] bval;
  logic       byte_ready, valid, lock, rep_ne, rep_e, seg_ov, opsize, addrsize, err;
  logic [7:0] opcode;
  logic [2:0] seg_idx;
  logic [3:0] cnt;

  logic       flush2, bvalid2, rdy2;
  logic [7:0] bval2;
  logic       byte_ready2, valid2, lock2, rep_ne22, rep_e2, seg_ov2, opsize2, addrsize2, err2;
  logic [7:0] opcode2;
  logic [2:0] seg_idx2;
  logic [1:0] cnt2;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];
  logic [21:0] exp2_q[$];

  decode_prefix_scanner dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(flush), .i_byte_valid(bvalid), .i_byte(bval),
    .o_byte_ready(byte_ready), .o_valid(valid), .i_ready(rdy), .o_opcode(opcode),
    .o_lock(lock), .o_rep_ne(rep_ne), .o_rep_e(rep_e), .o_seg_override(seg_ov),
    .o_seg_index(seg_idx), .o_opsize(opsize), .o_addrsize(addrsize),
    .o_prefix_count(cnt), .o_error(err)
  );

  decode_prefix_scanner #(.MAX_PREFIX(2)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(flush2), .i_byte_valid(bvalid2), .i_byte(bval2),
    .o_byte_ready(byte_ready2), .o_valid(valid2), .i_ready(rdy2), .o_opcode(opcode2),
    .o_lock(lock2), .o_rep_ne(rep_ne22), .o_rep_e(rep_e2), .o_seg_override(seg_ov2),
    .o_seg_index(seg_idx2), .o_opsize(opsize2), .o_addrsize(addrsize2),
    .o_prefix_count(cnt2), .o_error(err2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [21:0] mk(input logic [7:0] opc, input logic lk, input logic rne,
      input logic re, input logic sov, input logic [2:0] sidx, input logic os, input logic as_,
      input logic [3:0] c, input logic e);
    return {opc, lk, rne, re, sov, sidx, os, as_, c, e};
  endfunction

  function automatic logic [21:0] snap();
    return {opcode, lock, rep_ne, rep_e, seg_ov, seg_idx, opsize, addrsize, cnt, err};
  endfunction

  function automatic logic [21:0] snap2();
    return {opcode2, lock2, rep_ne22, rep_e2, seg_ov2, seg_idx2, opsize2, addrsize2, {2'b00, cnt2}, err2};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one byte starting just after a rising edge; returns just after the next one.
  task automatic send(input int which, input logic [7:0] b);
    if (which == 0) begin bvalid = 1'b1; bval = b; end
    else begin bvalid2 = 1'b1; bval2 = b; end
    @(posedge i_clk); #1;
    if (which == 0) bvalid = 1'b0; else bvalid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n && valid && rdy) begin
      if (exp_q.size() == 0) chk("unexpected_bundle", {10'd0, snap()}, 32'hFFFF_FFFF);
      else chk("bundle", {10'd0, snap()}, {10'd0, exp_q.pop_front()});
    end
    if (i_rst_n && valid2 && rdy2) begin
      if (exp2_q.size() == 0) chk("unexpected_bundle2", {10'd0, snap2()}, 32'hFFFF_FFFF);
      else chk("bundle2", {10'd0, snap2()}, {10'd0, exp2_q.pop_front()});
    end
  end

  initial begin
    i_rst_n = 1'b1; flush = 0; bvalid = 0; bval = 0; rdy = 1;
    flush2 = 0; bvalid2 = 0; bval2 = 0; rdy2 = 1;
    #2 i_rst_n = 1'b0;
    #1 chk("reset_bundle", {10'd0, snap()}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    @(negedge i_clk); @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_after_reset", {31'd0, byte_ready}, 32'd1);

    // Back-to-back instructions, downstream always ready.
    exp_q.push_back(mk(8'h90, 0, 0, 0, 0, 3'd0, 0, 0, 4'd0, 0));
    send(0, 8'h90);
    send(0, 8'h66); send(0, 8'h67); send(0, 8'hF3); send(0, 8'h2E);
    exp_q.push_back(mk(8'hA5, 0, 0, 1, 1, 3'd1, 1, 1, 4'd4, 0));
    send(0, 8'hA5);
    send(0, 8'hF0); send(0, 8'hF2); send(0, 8'hF3); send(0, 8'h26); send(0, 8'h65);
    exp_q.push_back(mk(8'h90, 0, 0, 1, 1, 3'd5, 0, 0, 4'd5, 0));
    send(0, 8'h90);
    send(0, 8'h64); send(0, 8'hF2); send(0, 8'h3E); send(0, 8'h36);
    exp_q.push_back(mk(8'h0F, 0, 1, 0, 1, 3'd2, 0, 0, 4'd4, 0));
    send(0, 8'h0F);
    repeat (14) send(0, 8'h66);
    exp_q.push_back(mk(8'h66, 0, 0, 0, 0, 3'd0, 1, 0, 4'd14, 1));
    send(0, 8'h66);
    idle(1);

    // Downstream stall: bundle must hold and no byte taken.
    rdy = 1'b0;
    send(0, 8'h65);
    exp_q.push_back(mk(8'hC3, 0, 0, 0, 1, 3'd5, 0, 0, 4'd1, 0));
    send(0, 8'hC3);
    bvalid = 1'b1; bval = 8'h90;
    repeat (3) begin
      @(negedge i_clk);
      chk("stall_valid", {31'd0, valid}, 32'd1);
      chk("stall_byte_ready", {31'd0, byte_ready}, 32'd0);
      chk("stall_bundle", {10'd0, snap()}, {10'd0, mk(8'hC3, 0, 0, 0, 1, 3'd5, 0, 0, 4'd1, 0)});
      @(posedge i_clk); #1;
    end
    rdy = 1'b1;
    exp_q.push_back(mk(8'h90, 0, 0, 0, 0, 3'd0, 0, 0, 4'd0, 0));
    @(posedge i_clk); #1;
    bvalid = 1'b0;
    idle(1);

    // Flush mid-scan.
    send(0, 8'h66); send(0, 8'hF2);
    flush = 1'b1; bvalid = 1'b1; bval = 8'h90;
    @(negedge i_clk);
    chk("flush_scan_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge i_clk); #1;
    flush = 1'b0; bvalid = 1'b0;
    chk("flush_scan_bundle", {10'd0, snap()}, 32'd0);
    chk("flush_scan_valid", {31'd0, valid}, 32'd0);
    idle(1);
    chk("flush_scan_no_accept", {31'd0, valid}, 32'd0);

    // Flush while holding an unconsumed bundle.
    rdy = 1'b0;
    send(0, 8'h66); send(0, 8'h90);
    @(negedge i_clk);
    chk("hold_before_flush", {31'd0, valid}, 32'd1);
    @(posedge i_clk); #1;
    flush = 1'b1; bvalid = 1'b1; bval = 8'h91;
    @(negedge i_clk);
    chk("flush_hold_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge i_clk); #1;
    flush = 1'b0; bvalid = 1'b0;
    chk("flush_hold_bundle", {10'd0, snap()}, 32'd0);
    chk("flush_hold_valid", {31'd0, valid}, 32'd0);
    rdy = 1'b1;

    // Async reset mid-scan discards the partial instruction.
    send(0, 8'h66); send(0, 8'h67); send(0, 8'hF0);
    #2 i_rst_n = 1'b0;
    #1 chk("async_rst_bundle", {10'd0, snap()}, 32'd0);
    chk("async_rst_valid", {31'd0, valid}, 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    chk("ready_after_async_rst", {31'd0, byte_ready}, 32'd1);
    exp_q.push_back(mk(8'h90, 0, 0, 0, 0, 3'd0, 0, 0, 4'd0, 0));
    send(0, 8'h90);

    // MAX_PREFIX=2 instance: overflow on the third prefix, then a clean follow-on.
    send(1, 8'h66); send(1, 8'h66);
    exp2_q.push_back(mk(8'h66, 0, 0, 0, 0, 3'd0, 1, 0, 4'd2, 1));
    send(1, 8'h66);
    send(1, 8'h67);
    exp2_q.push_back(mk(8'h8B, 0, 0, 0, 0, 3'd0, 0, 1, 4'd1, 0));
    send(1, 8'h8B);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp2_q.size() != 0); i++) idle(1);
    chk("drain_q", exp_q.size(), 32'd0);
    chk("drain_q2", exp2_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_prefix_scanner.md
DECODE_PREFIX_SCANNER -- requirements
Module: decode_prefix_scanner

Interface
REQ-001 SHALL have parameter MAX_PREFIX, default 14, maximum prefix bytes accepted per instruction (legal range 1..14).
REQ-002 SHALL have localparam CNT_W = $clog2(MAX_PREFIX+1), the width of the prefix counter.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_flush  input  1  synchronous abort of the current instruction.
REQ-006 SHALL have port i_byte_valid  input  1  instruction byte offered.
REQ-007 SHALL have port i_byte  input  8  instruction byte.
REQ-008 SHALL have port o_byte_ready  output  1  byte accepted when high together with i_byte_valid.
REQ-009 SHALL have port o_valid  output  1  prefix bundle and opcode byte available.
REQ-010 SHALL have port i_ready  input  1  downstream consumes the bundle.
REQ-011 SHALL have port o_opcode  output  8  first non-prefix byte, or the overflowing byte.
REQ-012 SHALL have ports o_lock, o_rep_ne, o_rep_e  output  1 each  group-1 result.
REQ-013 SHALL have ports o_seg_override (output, 1) and o_seg_index (output, 3): group-2 result.
REQ-014 SHALL have ports o_opsize and o_addrsize  output  1 each  group-3 and group-4 result.
REQ-015 SHALL have port o_prefix_count  output  CNT_W  number of prefix bytes consumed.
REQ-016 SHALL have port o_error  output  1  prefix-count overflow flag.

Function
REQ-017 SHALL implement two states: SCAN (collecting bytes) and HOLD (bundle presented).
REQ-018 SHALL recognise these prefix bytes: F0, F2, F3, 26, 2E, 36, 3E, 64, 65, 66, 67. Every other byte is an opcode.
REQ-019 SHALL always treat 2E and 3E as segment overrides, with no branch-hint decode.
REQ-020 SHALL map segment indices as ES(26)=0, CS(2E)=1, SS(36)=2, DS(3E)=3, FS(64)=4, GS(65)=5, per the shared index_reg_seg__ definitions.
REQ-021 SHALL drive o_byte_ready = !i_flush && (state==SCAN || (state==HOLD && i_ready)).
REQ-022 SHALL, on an accepted prefix byte with count<MAX_PREFIX, record the prefix, increment count and stay in SCAN.
REQ-023 SHALL resolve group 1 last-wins: F0 sets lock and clears both rep flags; F2 sets rep_ne and clears the others; F3 sets rep_e and clears the others.
REQ-024 SHALL resolve group 2 last-wins: set seg_override and overwrite seg_index with the latest byte's index.
REQ-025 SHALL treat 66 and 67 as sticky set flags; duplicate prefixes still increment count.
REQ-026 SHALL, on an accepted non-prefix byte, latch o_opcode and enter HOLD; o_valid rises the next cycle (latency 1).
REQ-027 SHALL, on an accepted prefix byte with count==MAX_PREFIX, set o_error, latch that byte into o_opcode, leave count at MAX_PREFIX and enter HOLD.
REQ-028 SHALL hold o_valid=1 and all bundle outputs stable in HOLD while i_ready=0.
REQ-029 SHALL, in HOLD with i_ready=1, clear all accumulators, flags, count and error; if a byte is accepted the same cycle it is processed as byte 0 of the next instruction against cleared state.
REQ-030 SHALL take the next state from the accepted byte's classification after a HOLD clear, otherwise return to SCAN.
REQ-031 SHALL give i_flush the highest priority: clear all state to reset values, enter SCAN and accept no byte that cycle, including in HOLD.
REQ-032 SHALL keep o_valid=0 and leave the state unchanged in SCAN when i_byte_valid=0.

Reset
REQ-033 SHALL, while i_rst_n=0, force state SCAN and hold o_valid, o_opcode, all flags, o_seg_index, o_prefix_count and o_error at 0 asynchronously.
REQ-034 SHALL allow o_byte_ready to go high the first cycle after i_rst_n deasserts, and SHALL discard any partial instruction held before reset.

Verification
REQ-035 SHALL cover: reset, then byte 90 -> next cycle o_valid=1, o_opcode=90, count=0, all flags 0, o_error=0.
REQ-036 SHALL cover: 66,67,F3,2E,A5 -> opsize=1, addrsize=1, rep_e=1, seg_override=1, seg_index=1, count=4, opcode=A5.
REQ-037 SHALL cover: F0,F2,F3,26,65,90 -> lock=0, rep_ne=0, rep_e=1, seg_index=5, count=5.
REQ-038 SHALL cover: MAX_PREFIX=2, bytes 66,66,66 -> o_error=1, opcode=66, count=2, o_valid=1.
REQ-039 SHALL cover: i_ready=0 for 3 cycles in HOLD -> outputs stable and o_byte_ready=0; then i_ready=1 with byte 90 -> accepted, next bundle has count=0, opcode=90.
REQ-040 SHALL cover: 66,F2, then i_flush in both SCAN and HOLD -> outputs cleared, o_valid=0, no byte accepted that cycle; async reset mid-scan -> identical clear.
